// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types for the data-memory arbiter.
//   arb_state_t  - arbiter FSM state
//   dmem_req_t   - one memory request (core, ext or the registered issue)
//   TimeoutRdata - read data returned when a transaction is abandoned
//   make_req     - builds a word-aligned request, wstrb cleared on loads
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitCore,
    StWaitExt
  } arb_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } dmem_req_t;

  localparam logic [31:0] TimeoutRdata = 32'h0000_0000;

  function automatic dmem_req_t make_req(input logic        we,
                                         input logic [31:0] addr,
                                         input logic [31:0] wdata,
                                         input logic [3:0]  wstrb);
    dmem_req_t r;
    r.we    = we;
    r.addr  = addr & 32'hFFFF_FFFC;
    r.wdata = wdata;
    r.wstrb = we ? wstrb : 4'b0000;
    return r;
  endfunction

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// dmem_arb_starve_ctr: saturating count of core grants taken while the
// external port is waiting.
//   clk_i, rst_ni - clock, async active-low reset
//   inc_i         - count one core grant (saturates at Limit)
//   clr_i         - clear (has priority over inc_i)
//   at_limit_o    - count has reached Limit
module dmem_arb_starve_ctr #(
  parameter int unsigned Limit = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  localparam int unsigned CntW = (Limit > 0) ? $clog2(Limit + 1) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CntW'(Limit))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == CntW'(Limit));

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the core MEM stage
// and one external (debug/DMA) requester. Core has priority, but after
// StarveLimit consecutive core grants with ext_valid waiting the external
// port wins. One transaction outstanding at a time.
//   clk, arst_n        - clock, async active-low reset
//   core_*             - MEM-stage request; core_stall freezes the pipeline,
//                        core_rdata is valid when core_req && !core_stall
//   ext_*              - external request (valid/ready), ext_rvalid pulse
//   mem_*              - registered issue strobe/fields, mem_rvalid/rdata back
// Optional: define DMEM_ARB_TIMEOUT_EN to abandon a transaction after
// TimeoutCycles wait cycles without mem_rvalid (rdata 0, timeout_err pulse).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned StarveLimit   = 4
`ifdef DMEM_ARB_TIMEOUT_EN
  , parameter int unsigned TimeoutCycles = 64
`endif
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [3:0]  core_wstrb,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  input  logic        ext_valid,
  output logic        ext_ready,
  input  logic        ext_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  input  logic [3:0]  ext_wstrb,
  output logic        ext_rvalid,
  output logic [31:0] ext_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
`ifdef DMEM_ARB_TIMEOUT_EN
  output logic        timeout_err,
`endif
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  arb_state_t  state_q, state_d;
  dmem_req_t   mem_q, mem_d;
  logic        mem_req_q, mem_req_d;
  logic        core_grant, ext_grant;
  logic        starve_at_limit;
  logic        timeout;
  logic        done;
  logic [31:0] resp_rdata;

  dmem_arb_starve_ctr #(
    .Limit (StarveLimit)
  ) u_starve_ctr (
    .clk_i      (clk),
    .rst_ni     (arst_n),
    .inc_i      (core_grant && ext_valid),
    .clr_i      (ext_grant || ((state_q == StIdle) && !ext_valid)),
    .at_limit_o (starve_at_limit)
  );

`ifdef DMEM_ARB_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);

  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (core_grant || ext_grant) begin
      tmo_cnt_d = '0;
    end else if ((state_q != StIdle) && !mem_rvalid) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // Fires in the last allowed wait cycle; a real mem_rvalid always wins.
  assign timeout = (state_q != StIdle) && !mem_rvalid &&
                   (tmo_cnt_q == TmoW'(TimeoutCycles - 1));
  assign timeout_err = timeout;
`else
  assign timeout = 1'b0;
`endif

  assign done       = mem_rvalid || timeout;
  assign resp_rdata = timeout ? TimeoutRdata : mem_rdata;

  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    mem_req_d  = 1'b0;
    core_grant = 1'b0;
    ext_grant  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (core_req && !(ext_valid && starve_at_limit)) begin
          core_grant = 1'b1;
          mem_d      = make_req(core_we, core_addr, core_wdata, core_wstrb);
          mem_req_d  = 1'b1;
          state_d    = StWaitCore;
        end else if (ext_valid) begin
          ext_grant = 1'b1;
          mem_d     = make_req(ext_we, ext_addr, ext_wdata, ext_wstrb);
          mem_req_d = 1'b1;
          state_d   = StWaitExt;
        end
      end
      // No re-arbitration in the completion cycle: always pass through idle.
      StWaitCore, StWaitExt: begin
        if (done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= StIdle;
      mem_q     <= '0;
      mem_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      mem_req_q <= mem_req_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_q.we;
  assign mem_addr  = mem_q.addr;
  assign mem_wdata = mem_q.wdata;
  assign mem_wstrb = mem_q.wstrb;

  assign ext_ready  = ext_grant;
  assign core_stall = core_req && !((state_q == StWaitCore) && done);
  assign core_rdata = resp_rdata;
  assign ext_rvalid = (state_q == StWaitExt) && done;
  assign ext_rdata  = resp_rdata;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between the core MEM stage (load/store from lsuop/dm_en decode) and one external requester (debug/DMA port). The core has priority, with a starvation limit so the external port is guaranteed service. Exactly one transaction is outstanding at a time. The block drives core_stall to freeze the pipeline while a core access is pending.

Parameters:
STARVE_LIMIT, 4, consecutive core grants allowed while ext_valid is waiting before the external port is forced to win
TIMEOUT_CYCLES, 64, WAIT-state cycles before a missing mem_rvalid is declared lost (used only with the optional feature)

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous active-low reset
core_req  in  1  MEM stage access request (dm_en or load); held stable while core_stall=1
core_we  in  1  1=store, 0=load
core_addr  in  32  byte address
core_wdata  in  32  store data
core_wstrb  in  4  byte enables
core_rdata  out  32  raw load data (goes to LSU for extension); valid when core_req=1 and core_stall=0
core_stall  out  1  freeze pipeline
ext_valid  in  1  external request valid
ext_ready  out  1  external request accepted this cycle
ext_we  in  1  store/load
ext_addr  in  32  byte address
ext_wdata  in  32  store data
ext_wstrb  in  4  byte enables
ext_rvalid  out  1  one-cycle completion pulse
ext_rdata  out  32  load data, valid with ext_rvalid
mem_req  out  1  registered one-cycle issue strobe
mem_we  out  1  registered
mem_addr  out  32  registered, word-aligned (bits 1:0 forced 0)
mem_wdata  out  32  registered
mem_wstrb  out  4  registered; 4'b0000 on loads
mem_rvalid  in  1  completion from memory (loads and stores), at least 1 cycle after mem_req
mem_rdata  in  32  read data, valid with mem_rvalid

Behaviour:
- Reset (async, any time, including mid-transaction): state=IDLE; mem_req/mem_we=0; mem_addr/mem_wdata=0; mem_wstrb=0; starve counter=0; ext_rvalid=0. A late mem_rvalid after reset is ignored.
- States: IDLE, WAIT_CORE, WAIT_EXT.
- IDLE arbitration each cycle:
  - core wins if core_req && !(ext_valid && starve_cnt==STARVE_LIMIT);
  - otherwise ext wins if ext_valid.
- On a grant: register the winner's fields onto mem_*; mem_req=1 on the next cycle only; go to WAIT_CORE or WAIT_EXT.
- ext_ready=1 (combinational) only in the IDLE cycle in which ext wins.
- Starve counter:
  - increments (saturating at STARVE_LIMIT) on each core grant while ext_valid=1;
  - clears on ext grant, or when ext_valid=0 in IDLE.
- WAIT_x: hold until mem_rvalid, then return to IDLE. No re-arbitration in the completion cycle.
- core_stall = core_req && !(state==WAIT_CORE && mem_rvalid). core_rdata = mem_rdata (pass-through).
- ext_rvalid = (state==WAIT_EXT && mem_rvalid); ext_rdata = mem_rdata.
- mem_rvalid in IDLE is ignored.
- Minimum core latency: request cycle T, mem_req at T+1, mem_rvalid at T+2 → stall high T..T+1, low T+2.
- Core requesting while WAIT_EXT: stall held until the ext transaction completes and the core is granted.
- Simultaneous core_req and ext_valid with counter below limit: core wins, ext_ready=0.

Optional Feature:
- DMEM_ARB_TIMEOUT_EN defined: a timeout counter runs in WAIT_x. After TIMEOUT_CYCLES cycles without mem_rvalid:
  - force completion with rdata=32'h0;
  - pulse extra output port timeout_err (1 bit, reset 0) for one cycle;
  - return to IDLE.
  - The counter clears on every grant.
- Undefined: no counter and no timeout_err port; WAIT_x waits indefinitely.

Decomposition:
- Package dmem_arb_pkg:
  - arb_state_t enum {IDLE, WAIT_CORE, WAIT_EXT};
  - dmem_req_t packed struct {we, addr[31:0], wdata[31:0], wstrb[3:0]} used for core, ext and registered mem request;
  - localparam for the timeout read-data value.
- Sub-module dmem_arb_starve_ctr: saturating counter with inc/clr/at_limit.

Test Plan:
- Core load addr 0x100, mem_rvalid 1 cycle after mem_req, rdata 0xCAFEF00D → mem_req at T+1 with mem_addr=0x100, mem_wstrb=0; stall high 2 cycles; core_rdata=0xCAFEF00D at T+2.
- Core store addr 0x203, wstrb 4'b1000, wdata 0x11223344 → mem_addr=0x200, mem_we=1, mem_wstrb=4'b1000; stall released on mem_rvalid.
- STARVE_LIMIT=4, core_req and ext_valid held continuously → 4 core grants, then ext_ready pulse and ext grant, then the core again.
- Ext load in WAIT_EXT while core_req rises → core_stall high; ext_rvalid with data first; core grant in the following IDLE cycle.
- Assert arst_n=0 in WAIT_CORE, release, then send a stray mem_rvalid → mem_req=0, state IDLE, no ext_rvalid, core_stall equals core_req.
- DMEM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8, mem_rvalid never arrives → after 8 WAIT cycles timeout_err pulses, core_rdata=0, stall drops.
